// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first bypass, busy scoreboard and post-reset zeroing sweep
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SIZE  = 5,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic                             CLK,
    input  logic                             rst,
    input  logic [NUM_RD*ADDR_SIZE-1:0]      RA,
    output logic [NUM_RD*DATA_WIDTH-1:0]     RD,
    output logic [NUM_RD-1:0]                RBUSY,
    input  logic [NUM_WR-1:0]                WE,
    input  logic [NUM_WR*ADDR_SIZE-1:0]      WA,
    input  logic [NUM_WR*DATA_WIDTH-1:0]     WD,
    input  logic                             ISSUE_EN,
    input  logic [ADDR_SIZE-1:0]             ISSUE_ADDR,
    output logic                             READY
);
    localparam int DEPTH = 2**ADDR_SIZE;
    typedef enum logic {INIT, RUN} state_t;
    state_t                 state;
    logic [ADDR_SIZE-1:0]   cnt;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]       busy, busy_nxt;
    // writeback clears first, a new issue then re-marks the destination
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WR; j++)
            if (WE[j]) busy_nxt[WA[j*ADDR_SIZE +: ADDR_SIZE]] = 1'b0;
        if (ISSUE_EN) busy_nxt[ISSUE_ADDR] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= '0;
            READY <= 1'b0;
        end else if (state == INIT) begin
            mem[cnt] <= '0;
            cnt      <= cnt + 1'b1;
            if (cnt == ADDR_SIZE'(DEPTH-1)) begin
                state <= RUN;
                READY <= 1'b1;
            end
        end else begin
            busy <= busy_nxt;
            for (int j = 0; j < NUM_WR; j++)
                if (WE[j] && WA[j*ADDR_SIZE +: ADDR_SIZE] != '0)
                    mem[WA[j*ADDR_SIZE +: ADDR_SIZE]] <= WD[j*DATA_WIDTH +: DATA_WIDTH];
        end
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_SIZE-1:0]  a;
        logic [DATA_WIDTH-1:0] d;
        logic                  hit;
        assign a = RA[k*ADDR_SIZE +: ADDR_SIZE];
        // ascending scan so the highest-index writer supplies the bypass
        always_comb begin
            d   = mem[a];
            hit = 1'b0;
            for (int j = 0; j < NUM_WR; j++)
                if (WE[j] && WA[j*ADDR_SIZE +: ADDR_SIZE] == a) begin
                    d   = WD[j*DATA_WIDTH +: DATA_WIDTH];
                    hit = 1'b1;
                end
        end
        assign RD[k*DATA_WIDTH +: DATA_WIDTH] = (state == RUN && a != '0) ? d : '0;
        assign RBUSY[k] = state == RUN && busy[a] && !hit;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed stimulus with a behavioural register-file model checked every cycle
module tb_regfile_mp;
    logic        CLK = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  ra = '0;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic [1:0]  we = '0;
    logic [9:0]  wa = '0;
    logic [63:0] wd = '0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_addr = '0;
    logic        ready;
    logic [11:0]  ra_b = '0;
    logic [127:0] rd_b;
    logic [3:0]   rbusy_b;
    logic         we_b = 1'b0;
    logic [2:0]   wa_b = '0;
    logic [31:0]  wd_b = '0;
    logic         issue_en_b = 1'b0;
    logic [2:0]   issue_addr_b = '0;
    logic         ready_b;
    int tests = 0;
    int fails = 0;
    regfile_mp dut (
        .CLK(CLK), .rst(rst), .RA(ra), .RD(rd), .RBUSY(rbusy), .WE(we), .WA(wa), .WD(wd),
        .ISSUE_EN(issue_en), .ISSUE_ADDR(issue_addr), .READY(ready)
    );
    regfile_mp #(.DATA_WIDTH(32), .ADDR_SIZE(3), .NUM_RD(4), .NUM_WR(1)) dut_b (
        .CLK(CLK), .rst(rst), .RA(ra_b), .RD(rd_b), .RBUSY(rbusy_b), .WE(we_b), .WA(wa_b), .WD(wd_b),
        .ISSUE_EN(issue_en_b), .ISSUE_ADDR(issue_addr_b), .READY(ready_b)
    );
    always #5 CLK = ~CLK;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic nxt;
        @(posedge CLK);
        #1;
    endtask
    // model: contents, busy set, and how many sweep edges have elapsed since reset
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    int          m_sweep;
    logic        m_ready;
    logic        started = 1'b0;
    always @(posedge CLK) begin
        if (!rst) begin
            started <= 1'b1;
            m_sweep <= 0;
            m_ready <= 1'b0;
            m_busy  <= '0;
        end else if (!m_ready) begin
            m_sweep <= m_sweep + 1;
            if (m_sweep == 31) begin
                m_ready <= 1'b1;
                for (int i = 0; i < 32; i++) m_mem[i] <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++)
                if (we[j] && wa[j*5 +: 5] != 0) m_mem[wa[j*5 +: 5]] <= wd[j*32 +: 32];
            for (int j = 0; j < 2; j++)
                if (we[j]) m_busy[wa[j*5 +: 5]] <= 1'b0;
            if (issue_en && issue_addr != 0) m_busy[issue_addr] <= 1'b1;
        end
    end
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!m_ready || a == 0) return '0;
        for (int j = 1; j >= 0; j--)
            if (we[j] && wa[j*5 +: 5] == a) return wd[j*32 +: 32];
        return m_mem[a];
    endfunction
    function automatic logic exp_busy(input logic [4:0] a);
        if (!m_ready || a == 0) return 1'b0;
        for (int j = 0; j < 2; j++)
            if (we[j] && wa[j*5 +: 5] == a) return 1'b0;
        return m_busy[a];
    endfunction
    always @(negedge CLK) begin
        if (started) begin
            chk("model_ready", {31'b0, ready}, {31'b0, m_ready});
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_rd%0d", k), rd[k*32 +: 32], exp_rd(ra[k*5 +: 5]));
                chk($sformatf("model_rbusy%0d", k), {31'b0, rbusy[k]}, {31'b0, exp_busy(ra[k*5 +: 5])});
            end
        end
    end
    initial begin
        nxt;
        nxt;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            we = 2'b11; wa = {5'd3, 5'd2}; wd = {32'hCAFE0000 + i, 32'hBEEF0000 + i};
            issue_en = 1'b1; issue_addr = 5'd4; ra = {5'd3, 5'd2};
            @(negedge CLK);
            chk("sweep_ready_low", {31'b0, ready}, 32'd0);
            chk("sweep_rd_zero", rd[31:0], 32'd0);
            nxt;
        end
        we = '0; issue_en = 1'b0;
        @(negedge CLK);
        chk("sweep_ready_high", {31'b0, ready}, 32'd1);
        nxt;
        for (int a = 0; a < 32; a++) begin
            ra = {5'(31 - a), 5'(a)};
            @(negedge CLK);
            chk("sweep_cleared", rd[31:0], 32'd0);
            chk("sweep_rbusy", {30'b0, rbusy}, 32'd0);
            nxt;
        end
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hDEADBEEF}; ra = {5'd0, 5'd5};
        @(negedge CLK);
        chk("bypass_same_cycle", rd[31:0], 32'hDEADBEEF);
        nxt;
        we = '0;
        @(negedge CLK);
        chk("write_stored", rd[31:0], 32'hDEADBEEF);
        nxt;
        we = 2'b11; wa = {5'd7, 5'd7}; wd = {32'h22222222, 32'h11111111}; ra = {5'd5, 5'd7};
        @(negedge CLK);
        chk("conflict_bypass", rd[31:0], 32'h22222222);
        nxt;
        we = '0;
        @(negedge CLK);
        chk("conflict_stored", rd[31:0], 32'h22222222);
        chk("other_entry_kept", rd[63:32], 32'hDEADBEEF);
        nxt;
        we = 2'b01; wa = {5'd0, 5'd0}; wd = {32'd0, 32'hFFFFFFFF}; ra = {5'd0, 5'd0};
        @(negedge CLK);
        chk("r0_bypass_zero", rd[31:0], 32'd0);
        nxt;
        we = '0;
        @(negedge CLK);
        chk("r0_stored_zero", rd[31:0], 32'd0);
        nxt;
        issue_en = 1'b1; issue_addr = 5'd9; ra = {5'd0, 5'd9};
        @(negedge CLK);
        chk("issue_not_yet_busy", {31'b0, rbusy[0]}, 32'd0);
        nxt;
        issue_en = 1'b0;
        @(negedge CLK);
        chk("issue_busy", {31'b0, rbusy[0]}, 32'd1);
        nxt;
        we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'hAAAA5555, 32'd0};
        @(negedge CLK);
        chk("wb_masks_busy", {31'b0, rbusy[0]}, 32'd0);
        chk("wb_bypass_data", rd[31:0], 32'hAAAA5555);
        nxt;
        we = '0;
        @(negedge CLK);
        chk("wb_cleared", {31'b0, rbusy[0]}, 32'd0);
        nxt;
        we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h0BADF00D, 32'd0}; issue_en = 1'b1; issue_addr = 5'd9;
        @(negedge CLK);
        chk("issue_wb_same_masked", {31'b0, rbusy[0]}, 32'd0);
        nxt;
        we = '0; issue_en = 1'b0;
        @(negedge CLK);
        chk("issue_beats_clear", {31'b0, rbusy[0]}, 32'd1);
        nxt;
        issue_en = 1'b1; issue_addr = 5'd0; ra = {5'd0, 5'd9};
        nxt;
        issue_en = 1'b0;
        @(negedge CLK);
        chk("r0_never_busy", {31'b0, rbusy[1]}, 32'd0);
        nxt;
        we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h12345678}; issue_en = 1'b1; issue_addr = 5'd4;
        nxt;
        we = '0; issue_en = 1'b0; ra = {5'd4, 5'd3};
        @(negedge CLK);
        chk("pre_reset_r3", rd[31:0], 32'h12345678);
        chk("pre_reset_r4_busy", {31'b0, rbusy[1]}, 32'd1);
        nxt;
        rst = 1'b0;
        nxt;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge CLK);
            chk("rerun_ready_low", {31'b0, ready}, 32'd0);
            chk("rerun_busy_clear", {31'b0, rbusy[1]}, 32'd0);
            chk("b_sweep_ready", {31'b0, ready_b}, (i >= 8) ? 32'd1 : 32'd0);
            nxt;
        end
        @(negedge CLK);
        chk("rerun_ready_high", {31'b0, ready}, 32'd1);
        chk("rerun_r3_zero", rd[31:0], 32'd0);
        chk("rerun_r4_not_busy", {31'b0, rbusy[1]}, 32'd0);
        nxt;
        we_b = 1'b1; wa_b = 3'd1; wd_b = 32'h000000A1;
        nxt;
        wa_b = 3'd2; wd_b = 32'h000000B2;
        nxt;
        wa_b = 3'd3; wd_b = 32'h000000C3;
        nxt;
        wa_b = 3'd5; wd_b = 32'h000000E5;
        nxt;
        we_b = 1'b0; ra_b = {3'd5, 3'd3, 3'd2, 3'd1};
        @(negedge CLK);
        chk("b_p0", rd_b[31:0], 32'hA1);
        chk("b_p1", rd_b[63:32], 32'hB2);
        chk("b_p2", rd_b[95:64], 32'hC3);
        chk("b_p3", rd_b[127:96], 32'hE5);
        nxt;
        ra_b = {3'd1, 3'd2, 3'd3, 3'd5};
        @(negedge CLK);
        chk("b_p0_swap", rd_b[31:0], 32'hE5);
        chk("b_p3_swap", rd_b[127:96], 32'hA1);
        nxt;
        we_b = 1'b1; wa_b = 3'd6; wd_b = 32'h000000F6; ra_b = {3'd6, 3'd6, 3'd0, 3'd6};
        @(negedge CLK);
        chk("b_byp_p0", rd_b[31:0], 32'hF6);
        chk("b_byp_p1_r0", rd_b[63:32], 32'd0);
        chk("b_byp_p2", rd_b[95:64], 32'hF6);
        chk("b_byp_p3", rd_b[127:96], 32'hF6);
        nxt;
        we_b = 1'b0; issue_en_b = 1'b1; issue_addr_b = 3'd4;
        nxt;
        issue_en_b = 1'b0; ra_b = {3'd2, 3'd4, 3'd0, 3'd6};
        @(negedge CLK);
        chk("b_stored_p0", rd_b[31:0], 32'hF6);
        chk("b_rbusy", {28'b0, rbusy_b}, 32'h4);
        nxt;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
